pw_key_entry: RTL
=================

// Module: pw_key_entry
// PURPOSE
//  Upstream stage of the password checker. Collects keypad codes into a NUM_DIGITS-digit
//  entry, supports BACKSPACE, CLEAR, ENTER and an inactivity timeout.
//  On ENTER with a full entry, presents pw_16bit and pulses enb_cmp for one cycle.
//  Honours the lockout flag gen_stop from the error processor.
// PARAMETERS
//  NUM_DIGITS      4           digits per entry; pw width = NUM_DIGITS*4 (16 at default)
//  TIMEOUT_CYCLES  50_000_000  idle cycles in ENTRY/FULL before the entry is discarded (>=2)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  reset       in   1   synchronous, active-high reset
//  key_valid   in   1   one-cycle strobe: key_code valid this cycle
//  key_code    in   4   0x0-0x9 digit, 0xA CLEAR, 0xB BACK, 0xE ENTER, 0xC/0xD/0xF unused
//  gen_stop    in   1   lockout active: discard entry, ignore keys
//  pw_16bit    out  16  entered digits; first digit in [15:12], last digit in [3:0]
//  enb_cmp     out  1   one-cycle compare request; pw_16bit is valid in the same cycle
//  digit_cnt   out  3   digits currently held, 0..NUM_DIGITS
//  entry_busy  out  1   high in ENTRY, FULL and SUBMIT
//  short_err   out  1   one-cycle pulse: ENTER pressed with 0 < digit_cnt < NUM_DIGITS
//  timeout     out  1   one-cycle pulse: entry discarded by inactivity
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; idle counter 0. Reset overrides everything.
//  Timing: all outputs are registered. A key sampled at edge E takes effect in the cycle after E.
//  Accepted key: key_valid=1, code is not unused, and gen_stop=0. Unused codes have no effect.
//  Digit shift-in: pw <= {pw[11:0],d}; cnt+1. BACK: pw <= {4'h0,pw[15:4]}; cnt-1.
//  FSM states:
//   IDLE   : cnt=0, pw=0. Digit -> ENTRY (cnt=1). BACK, CLEAR and ENTER are ignored.
//   ENTRY  : Digit -> shift in; go FULL when cnt reaches NUM_DIGITS.
//            BACK -> cnt-1; go IDLE when cnt reaches 0.
//            CLEAR -> IDLE. ENTER -> short_err=1, go IDLE.
//   FULL   : Digit ignored (pw unchanged, but the idle counter restarts). BACK -> ENTRY.
//            CLEAR -> IDLE. ENTER -> SUBMIT.
//   SUBMIT : exactly one cycle. enb_cmp=1; pw_16bit and digit_cnt hold the full entry.
//            Keys are ignored. Next edge: pw=0, cnt=0, -> IDLE.
//  Going to IDLE always clears pw and cnt on the same edge.
//  Inactivity timeout (ENTRY and FULL only):
//   - The idle counter clears on every accepted key and on every entry to IDLE.
//   - Otherwise it increments each cycle.
//   - When it reaches TIMEOUT_CYCLES: go IDLE, timeout=1 for one cycle.
//   - If an accepted key arrives on the expiry edge, the key is processed and no timeout occurs.
//  gen_stop=1:
//   - In IDLE, ENTRY or FULL: go IDLE and clear on the next edge; no error pulses.
//   - In SUBMIT: the enb_cmp cycle completes normally.
//   - Keys are ignored for as long as gen_stop stays high.
//  Priority per edge: reset > SUBMIT completion > gen_stop > accepted key > timeout.
//  short_err, timeout and enb_cmp are never high in the same cycle.
// TESTING (TIMEOUT_CYCLES=8 for the bench)
//  1 Reset high 2 cycles mid-entry (cnt=3) -> all outputs 0, digit_cnt=0 next cycle.
//  2 Keys 1,2,3,4,ENTER -> enb_cmp=1 for exactly 1 cycle with pw_16bit=16'h1234;
//    next cycle pw=0, cnt=0.
//  3 Keys 1,2,3,4,5,BACK,9,ENTER -> 5 ignored; enb_cmp pulse with pw_16bit=16'h1239.
//  4 Keys 7,ENTER -> short_err 1 cycle, no enb_cmp, cnt=0; then 0xC/0xF -> no change.
//  5 gen_stop=1 at cnt=2 -> cleared next cycle; keys 1-4 + ENTER while high -> pw stays 0.
//  6 Key 5 then 8 idle cycles -> timeout pulse, cnt=0.
//    Key on the 8th cycle -> no timeout, cnt=2.

Source files
------------

// File: rtl/pw_key_entry_if.sv
// Keypad-entry bus: key strobes and lockout in, assembled password and status pulses out.
interface pw_key_entry_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned CntW = $clog2(NUM_DIGITS + 1);

    logic                    key_valid;
    logic [3:0]              key_code;
    logic                    gen_stop;
    logic [NUM_DIGITS*4-1:0] pw_16bit;
    logic                    enb_cmp;
    logic [CntW-1:0]         digit_cnt;
    logic                    entry_busy;
    logic                    short_err;
    logic                    timeout;

    modport master (
        output key_valid, key_code, gen_stop,
        input  pw_16bit, enb_cmp, digit_cnt, entry_busy, short_err, timeout
    );

    modport slave (
        input  key_valid, key_code, gen_stop,
        output pw_16bit, enb_cmp, digit_cnt, entry_busy, short_err, timeout
    );
endinterface

// File: rtl/pw_key_entry.sv
// Keypad digit collector for the password checker: edits, submits, times out and honours lockout.
module pw_key_entry #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input logic           clk,
    input logic           reset,
    pw_key_entry_if.slave bus_io
);
    localparam int unsigned PwW   = NUM_DIGITS * 4;
    localparam int unsigned CntW  = $clog2(NUM_DIGITS + 1);
    // Counter only needs 0..TIMEOUT_CYCLES-1: expiry fires on the edge it would hit the limit.
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES);

    localparam logic [CntW-1:0]  CntFull  = CntW'(NUM_DIGITS);
    localparam logic [CntW-1:0]  CntOne   = CntW'(1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] KeyClear = 4'hA;
    localparam logic [3:0] KeyBack  = 4'hB;
    localparam logic [3:0] KeyEnter = 4'hE;

    typedef enum logic [1:0] {StIdle, StEntry, StFull, StSubmit} state_e;

    state_e           state_q;
    logic [PwW-1:0]   pw_q;
    logic [CntW-1:0]  cnt_q;
    logic [IdleW-1:0] idle_q;
    logic             enb_cmp_q;
    logic             short_err_q;
    logic             timeout_q;

    logic [3:0] code;
    logic       is_digit, is_clear, is_back, is_enter, key_acc;

    always_comb begin
        code     = bus_io.key_code;
        is_digit = (code <= 4'd9);
        is_clear = (code == KeyClear);
        is_back  = (code == KeyBack);
        is_enter = (code == KeyEnter);
        key_acc  = bus_io.key_valid && !bus_io.gen_stop &&
                   (is_digit || is_clear || is_back || is_enter);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pw_q        <= '0;
            cnt_q       <= '0;
            idle_q      <= '0;
            enb_cmp_q   <= 1'b0;
            short_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            enb_cmp_q   <= 1'b0;
            short_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            if (state_q == StSubmit || bus_io.gen_stop) begin
                state_q <= StIdle;
                pw_q    <= '0;
                cnt_q   <= '0;
                idle_q  <= '0;
            end else if (key_acc) begin
                idle_q <= '0;
                unique case (state_q)
                    StIdle: begin
                        if (is_digit) begin
                            pw_q    <= {pw_q[PwW-5:0], code};
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= (CntOne == CntFull) ? StFull : StEntry;
                        end
                    end
                    StEntry: begin
                        if (is_digit) begin
                            pw_q  <= {pw_q[PwW-5:0], code};
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == CntFull - 1'b1) state_q <= StFull;
                        end else if (is_back && cnt_q != CntOne) begin
                            pw_q  <= {4'h0, pw_q[PwW-1:4]};
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            // Last BACK, CLEAR or a premature ENTER all abandon the entry.
                            state_q     <= StIdle;
                            pw_q        <= '0;
                            cnt_q       <= '0;
                            short_err_q <= is_enter;
                        end
                    end
                    StFull: begin
                        if (is_back) begin
                            pw_q    <= {4'h0, pw_q[PwW-1:4]};
                            cnt_q   <= cnt_q - 1'b1;
                            state_q <= StEntry;
                        end else if (is_clear) begin
                            state_q <= StIdle;
                            pw_q    <= '0;
                            cnt_q   <= '0;
                        end else if (is_enter) begin
                            state_q   <= StSubmit;
                            enb_cmp_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (state_q == StEntry || state_q == StFull) begin
                if (idle_q == IdleLast) begin
                    state_q   <= StIdle;
                    pw_q      <= '0;
                    cnt_q     <= '0;
                    idle_q    <= '0;
                    timeout_q <= 1'b1;
                end else begin
                    idle_q <= idle_q + 1'b1;
                end
            end
        end
    end

    assign bus_io.pw_16bit   = pw_q;
    assign bus_io.digit_cnt  = cnt_q;
    assign bus_io.enb_cmp    = enb_cmp_q;
    assign bus_io.short_err  = short_err_q;
    assign bus_io.timeout    = timeout_q;
    assign bus_io.entry_busy = (state_q != StIdle);
endmodule
